reg_status_table: RTL and testbench
===================================

REG_STATUS_TABLE -- requirements
Module: reg_status_table

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32: architectural registers tracked; power of two, 4..64.
REQ-002 SHALL have parameter TAG_W, default 6: reservation-station tag width; tag 0 is reserved as "no producer".
REQ-003 SHALL have parameter NUM_LOOKUP, default 2: number of operand lookup ports, 1..4.
REQ-004 SHALL derive RIDX_W = clog2(NUM_REGS) and CNT_W = clog2(NUM_REGS+1).
REQ-005 SHALL have port Clock, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port issue_valid, input, 1 bit: issue a destination claim this cycle.
REQ-008 SHALL have port issue_reg, input, RIDX_W bits: destination register index.
REQ-009 SHALL have port issue_tag, input, TAG_W bits: producing station tag.
REQ-010 SHALL have port cdb_valid, input, 1 bit: common-data-bus broadcast valid.
REQ-011 SHALL have port cdb_tag, input, TAG_W bits: tag of the completing station.
REQ-012 SHALL have port flush, input, 1 bit: squash all pending claims.
REQ-013 SHALL have port lookup_reg, input, NUM_LOOKUP*RIDX_W bits: packed source register indices.
REQ-014 SHALL have port lookup_busy, output, NUM_LOOKUP bits: per-port pending-producer flag.
REQ-015 SHALL have port lookup_tag, output, NUM_LOOKUP*TAG_W bits: per-port producer tag, 0 when not busy.
REQ-016 SHALL have port busy_vec, output, NUM_REGS bits: registered per-register busy flags.
REQ-017 SHALL have port busy_count, output, CNT_W bits: registered population count of busy_vec.

Function
REQ-018 Each entry SHALL hold busy (1 bit) and tag (TAG_W); a non-busy entry SHALL hold tag 0.
REQ-019 Issue SHALL take effect when issue_valid=1, issue_reg!=0 and issue_tag!=0; at the next edge entry[issue_reg] becomes busy=1, tag=issue_tag, overwriting any previous claim (WAW rename).
REQ-020 Issue to register 0 or with tag 0 SHALL be ignored; register 0 is never busy.
REQ-021 On cdb_valid=1 with cdb_tag!=0, every entry with busy=1 and tag==cdb_tag SHALL clear to busy=0, tag=0 at the next edge; multiple matches clear together.
REQ-022 When the same edge sees an issue and a CDB match on the issued register, issue SHALL win (the entry holds the new tag).
REQ-023 flush=1 SHALL clear all entries at the next edge, overriding issue and CDB in that cycle.
REQ-024 Lookups SHALL be combinational with zero latency: lookup_busy[i] = entry busy AND NOT (cdb_valid AND cdb_tag==entry tag); lookup_tag[i] = entry tag when lookup_busy[i]=1, else 0.
REQ-025 Lookups SHALL NOT forward a same-cycle issue; the new claim becomes visible one cycle after issue.
REQ-026 busy_count SHALL equal the popcount of busy_vec in every cycle, both updated at the same edge; maximum value NUM_REGS-1.
REQ-027 Inputs SHALL be sampled only at the rising edge of Clock; no handshake back-pressure exists, and an issue is always accepted in one cycle.

Reset
REQ-028 Resetn=0 SHALL immediately clear all busy flags, tags, busy_vec and busy_count to 0, independent of Clock.
REQ-029 Reset asserted during any activity SHALL discard all pending claims; the first edge after deassertion SHALL process inputs normally.

Structure
REQ-030 A shared package SHALL hold the constant TAG_NONE = 0 and the default values of NUM_REGS and TAG_W.
REQ-031 One sub-module, reg_status_entry, SHALL implement a single busy/tag entry with set, CDB-match-clear and flush; it is instantiated NUM_REGS times by generate.
REQ-032 The lookup multiplexers and the popcount SHALL reside in the top module.

Verification
REQ-033 Reset, then issue reg 5 with tag 3 -> next cycle busy_vec[5]=1, busy_count=1, lookup of reg 5 gives busy=1, tag=3.
REQ-034 Regs 2 and 7 both busy with tag 4, cdb_tag=4 -> same-cycle lookup_busy=0 for both; next cycle both clear and busy_count drops by 2.
REQ-035 Reg 9 holds tag 1; same cycle issue reg 9 tag 2 and cdb_tag=1 -> next cycle reg 9 is busy with tag 2.
REQ-036 Issue to reg 0 with tag 5, and issue to reg 3 with tag 0 -> busy_vec stays 0.
REQ-037 Ten regs busy, then flush together with an issue to reg 4 -> next cycle busy_vec=0, busy_count=0.
REQ-038 Resetn pulsed low mid-cycle with regs busy -> outputs clear before the next edge.

Source files
------------

// File: rtl/reg_status_table_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_status_table_pkg
// Purpose : Shared constants for the register status table: the reserved
//           "no producer" tag and the default table geometry.
// Revision: 1.0 - initial release
// ============================================================================
package reg_status_table_pkg;

  // Tag value meaning "no pending producer"; never a real station tag.
  localparam int TAG_NONE = 0;

  // Default geometry shared by the top and the entry sub-module.
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int TAG_W_DEFAULT    = 6;

endpackage : reg_status_table_pkg
`default_nettype wire

// File: rtl/reg_status_entry.sv
`default_nettype none
// ============================================================================
// Module  : reg_status_entry
// Purpose : One busy/tag entry of the register status table.
//           Priority on a clock edge: flush > set (issue) > CDB-match clear.
// Ports   : clk, rst_n      - clock, asynchronous active-low reset
//           set_i/set_tag_i - claim this entry for a producer tag
//           cdb_valid_i/cdb_tag_i - completion broadcast
//           flush_i         - squash the claim
//           busy_o/tag_o    - registered entry state
//           busy_d_o        - next-state busy, used for the registered count
// Revision: 1.0 - initial release
// ============================================================================
module reg_status_entry
  import reg_status_table_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_i,
  input  logic [TAG_W-1:0] set_tag_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             busy_d_o
);

  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

  logic             busy_q, busy_d;
  logic [TAG_W-1:0] tag_q,  tag_d;
  logic             cdb_match;

  // A zero CDB tag never matches, so an idle bus with tag 0 is harmless.
  assign cdb_match = cdb_valid_i && (cdb_tag_i != NO_TAG) &&
                     busy_q && (tag_q == cdb_tag_i);

  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    if (flush_i) begin
      busy_d = 1'b0;
      tag_d  = NO_TAG;
    end else if (set_i) begin
      // A new claim beats a same-cycle completion of the old producer.
      busy_d = 1'b1;
      tag_d  = set_tag_i;
    end else if (cdb_match) begin
      busy_d = 1'b0;
      tag_d  = NO_TAG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      tag_q  <= NO_TAG;
    end else begin
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign busy_o   = busy_q;
  assign tag_o    = tag_q;
  assign busy_d_o = busy_d;

endmodule : reg_status_entry
`default_nettype wire

// File: rtl/reg_status_table.sv
`default_nettype none
// ============================================================================
// Module  : reg_status_table
// Purpose : Register status (rename) table for a Tomasulo-style core. Tracks,
//           per architectural register, whether a reservation station will
//           produce it and which tag. Offers combinational operand lookups
//           that already account for a same-cycle CDB completion.
// Ports   : Clock, Resetn              - clock, async active-low reset
//           issue_valid/reg/tag        - destination claim
//           cdb_valid/cdb_tag          - completion broadcast
//           flush                      - squash all claims
//           lookup_reg -> lookup_busy/lookup_tag  (NUM_LOOKUP ports)
//           busy_vec, busy_count       - registered status summary
// Revision: 1.0 - initial release
// ============================================================================
module reg_status_table
  import reg_status_table_pkg::*;
#(
  parameter  int NUM_REGS   = NUM_REGS_DEFAULT,
  parameter  int TAG_W      = TAG_W_DEFAULT,
  parameter  int NUM_LOOKUP = 2,
  localparam int RIDX_W     = $clog2(NUM_REGS),
  localparam int CNT_W      = $clog2(NUM_REGS + 1)
) (
  input  logic                         Clock,
  input  logic                         Resetn,
  input  logic                         issue_valid,
  input  logic [RIDX_W-1:0]            issue_reg,
  input  logic [TAG_W-1:0]             issue_tag,
  input  logic                         cdb_valid,
  input  logic [TAG_W-1:0]             cdb_tag,
  input  logic                         flush,
  input  logic [NUM_LOOKUP*RIDX_W-1:0] lookup_reg,
  output logic [NUM_LOOKUP-1:0]        lookup_busy,
  output logic [NUM_LOOKUP*TAG_W-1:0]  lookup_tag,
  output logic [NUM_REGS-1:0]          busy_vec,
  output logic [CNT_W-1:0]             busy_count
);

  localparam logic [TAG_W-1:0] NO_TAG = TAG_W'(TAG_NONE);

  logic [NUM_REGS-1:0] ent_busy;
  logic [NUM_REGS-1:0] ent_busy_d;
  logic [TAG_W-1:0]    ent_tag [NUM_REGS];
  logic                issue_ok;
  logic [CNT_W-1:0]    count_q, count_d;

  assign issue_ok = issue_valid && (issue_tag != NO_TAG);

  // Register 0 is hard-wired: its entry never sees a set, so it stays idle.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_entry
    logic set_w;
    assign set_w = (r != 0) && issue_ok && (issue_reg == RIDX_W'(r));

    reg_status_entry #(
      .TAG_W (TAG_W)
    ) u_entry (
      .clk         (Clock),
      .rst_n       (Resetn),
      .set_i       (set_w),
      .set_tag_i   (issue_tag),
      .cdb_valid_i (cdb_valid),
      .cdb_tag_i   (cdb_tag),
      .flush_i     (flush),
      .busy_o      (ent_busy[r]),
      .tag_o       (ent_tag[r]),
      .busy_d_o    (ent_busy_d[r])
    );
  end

  // Lookups bypass a completing producer but never forward a same-cycle issue.
  for (genvar i = 0; i < NUM_LOOKUP; i++) begin : g_lookup
    logic [RIDX_W-1:0] idx;
    logic [TAG_W-1:0]  etag;
    logic              cdb_hit;
    assign idx     = lookup_reg[i*RIDX_W +: RIDX_W];
    assign etag    = ent_tag[idx];
    assign cdb_hit = cdb_valid && (cdb_tag == etag);
    assign lookup_busy[i]              = ent_busy[idx] && !cdb_hit;
    assign lookup_tag[i*TAG_W +: TAG_W] = lookup_busy[i] ? etag : NO_TAG;
  end

  // Count the next-state flags so busy_count updates on the same edge as busy_vec.
  always_comb begin
    count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      count_d = count_d + CNT_W'(ent_busy_d[r]);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign busy_vec   = ent_busy;
  assign busy_count = count_q;

endmodule : reg_status_table
`default_nettype wire

// File: tb/tb_reg_status_table.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_status_table
// Purpose : Self-checking bench for reg_status_table. A driver issues one
//           stimulus vector per cycle, predicts the DUT outputs from an
//           array-based model and queues them; a monitor compares at negedge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_reg_status_table;

  localparam int NR = 32;
  localparam int TW = 6;
  localparam int NL = 2;
  localparam int RW = 5;
  localparam int CW = 6;

  logic             Clock = 1'b0;
  logic             Resetn;
  logic             issue_valid;
  logic [RW-1:0]    issue_reg;
  logic [TW-1:0]    issue_tag;
  logic             cdb_valid;
  logic [TW-1:0]    cdb_tag;
  logic             flush;
  logic [NL*RW-1:0] lookup_reg;
  logic [NL-1:0]    lookup_busy;
  logic [NL*TW-1:0] lookup_tag;
  logic [NR-1:0]    busy_vec;
  logic [CW-1:0]    busy_count;

  reg_status_table #(
    .NUM_REGS   (NR),
    .TAG_W      (TW),
    .NUM_LOOKUP (NL)
  ) dut (
    .Clock       (Clock),
    .Resetn      (Resetn),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .issue_tag   (issue_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .flush       (flush),
    .lookup_reg  (lookup_reg),
    .lookup_busy (lookup_busy),
    .lookup_tag  (lookup_tag),
    .busy_vec    (busy_vec),
    .busy_count  (busy_count)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [NR-1:0]    vec;
    int               cnt;
    logic [NL-1:0]    lb;
    logic [NL*TW-1:0] lt;
  } exp_t;

  exp_t q[$];
  bit   m_busy[NR];
  int   m_tag[NR];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NR-1:0] model_vec();
    logic [NR-1:0] v = '0;
    for (int r = 0; r < NR; r++) v[r] = m_busy[r];
    return v;
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int r = 0; r < NR; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < NR; r++) begin
      m_busy[r] = 1'b0;
      m_tag[r]  = 0;
    end
  endfunction

  // One cycle: drive, predict this cycle's outputs, then advance the model.
  task automatic drive(input bit iv, input int ir, input int it, input bit cv,
                       input int ct, input bit fl, input int l0, input int l1);
    exp_t e;
    int   lr[NL];
    issue_valid = iv;
    issue_reg   = RW'(ir);
    issue_tag   = TW'(it);
    cdb_valid   = cv;
    cdb_tag     = TW'(ct);
    flush       = fl;
    lookup_reg  = {RW'(l1), RW'(l0)};
    lr[0] = l0;
    lr[1] = l1;
    e.vec = model_vec();
    e.cnt = model_cnt();
    e.lb  = '0;
    e.lt  = '0;
    for (int i = 0; i < NL; i++) begin
      bit completing = cv && (ct == m_tag[lr[i]]);
      if (m_busy[lr[i]] && !completing) begin
        e.lb[i]          = 1'b1;
        e.lt[i*TW +: TW] = TW'(m_tag[lr[i]]);
      end
    end
    q.push_back(e);
    if (fl) begin
      model_clear();
    end else begin
      if (cv && ct != 0)
        for (int r = 0; r < NR; r++)
          if (m_busy[r] && m_tag[r] == ct) begin
            m_busy[r] = 1'b0;
            m_tag[r]  = 0;
          end
      if (iv && ir != 0 && it != 0) begin
        m_busy[ir] = 1'b1;
        m_tag[ir]  = it;
      end
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idle(input int l0, input int l1);
    drive(0, 0, 0, 0, 0, 0, l0, l1);
  endtask

  always @(negedge Clock) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      check("busy_vec",    64'(busy_vec),    64'(e.vec));
      check("busy_count",  64'(busy_count),  64'(e.cnt));
      check("lookup_busy", 64'(lookup_busy), 64'(e.lb));
      check("lookup_tag",  64'(lookup_tag),  64'(e.lt));
    end
  end

  initial begin
    int wait_cyc;
    int ct;
    issue_valid = 0; issue_reg = '0; issue_tag = '0;
    cdb_valid = 0; cdb_tag = '0; flush = 0; lookup_reg = '0;
    model_clear();
    Resetn = 1'b0;
    #3;
    check("reset_vec_async", 64'(busy_vec), 64'd0);
    check("reset_cnt_async", 64'(busy_count), 64'd0);
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;

    // Basic claim, visible one cycle later.
    drive(1, 5, 3, 0, 0, 0, 5, 0);
    idle(5, 0);
    // Two registers completing on one broadcast.
    drive(1, 2, 4, 0, 0, 0, 2, 7);
    drive(1, 7, 4, 0, 0, 0, 2, 7);
    drive(0, 0, 0, 1, 4, 0, 2, 7);
    idle(2, 7);
    // Re-issue beats a same-cycle completion of the old tag.
    drive(1, 9, 1, 0, 0, 0, 9, 9);
    drive(1, 9, 2, 1, 1, 0, 9, 9);
    idle(9, 5);
    // Ignored issues.
    drive(0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 5, 0, 0, 0, 0, 3);
    drive(1, 3, 0, 0, 0, 0, 0, 3);
    idle(0, 3);
    // Flush overrides a same-cycle issue.
    for (int r = 1; r <= 10; r++) drive(1, r, r + 10, 0, 0, 0, r, 4);
    drive(1, 4, 7, 0, 0, 1, 4, 1);
    idle(4, 1);

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      int r = $urandom_range(0, NR - 1);
      if ($urandom_range(0, 3) != 0) ct = m_tag[$urandom_range(0, NR - 1)];
      else                           ct = $urandom_range(0, 7);
      drive($urandom_range(0, 9) < 6, r, $urandom_range(0, 7),
            $urandom_range(0, 1) == 1, ct, $urandom_range(0, 39) == 0,
            ($urandom_range(0, 3) == 0) ? r : $urandom_range(0, NR - 1),
            $urandom_range(0, NR - 1));
    end

    // Asynchronous reset in the middle of a cycle with claims pending.
    drive(1, 12, 9, 0, 0, 0, 12, 0);
    drive(1, 13, 10, 0, 0, 0, 12, 13);
    check("pre_reset_vec", 64'(busy_vec), 64'(model_vec()));
    #2;
    Resetn = 1'b0;
    #1;
    check("midreset_vec", 64'(busy_vec), 64'd0);
    check("midreset_cnt", 64'(busy_count), 64'd0);
    check("midreset_lookup", 64'(lookup_busy), 64'd0);
    model_clear();
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    drive(1, 6, 2, 0, 0, 0, 6, 12);
    idle(6, 12);

    wait_cyc = 0;
    while (q.size() != 0 && wait_cyc < 10) begin
      @(negedge Clock);
      #1;
      wait_cyc++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_reg_status_table
`default_nettype wire
